gb_fb_writer: RTL

GB_FB_WRITER -- requirements
Module: gb_fb_writer

---
 rtl/gb_fb_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gb_fb_writer.sv
// Framebuffer writer: turns the PPU pixel stream into shaded, addressed
// framebuffer word writes through a small pending-write FIFO, tracking
// line/frame position from the PPU mode sequence and flagging malformed
// lines and FIFO overflow.
module gb_fb_writer #(
  parameter logic [14:0] FB_BASE    = 15'h0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LINE_W     = 160,
  parameter int unsigned LINES      = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_on,
  input  logic [7:0]  bgp,
  input  logic        fb_ready,
  input  logic        err_clr,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        frame_done,
  output logic        line_err,
  output logic        ovf_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned COL_W = $clog2(LINE_W + 1);
  localparam int unsigned ROW_W = $clog2(LINES + 1) + 1;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_DRAW   = 2'd3;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_VB_END,
    ACTIVE,
    FRAME_END
  } state_e;

  state_e           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [14:0]      line_base;
  logic [1:0]       prev_mode;

  logic [14:0]      mem_addr [FIFO_DEPTH];
  logic [1:0]       mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic       in_active;
  logic       px_room;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       ovf_drop;
  logic       over_drop;
  logic       line_end;
  logic [1:0] shade;

  assign fb_we   = (count != '0);
  assign fb_addr = mem_addr[rd_ptr];
  assign fb_data = mem_data[rd_ptr];

  // Pixel acceptance / drop decisions and palette lookup for this cycle.
  always_comb begin
    in_active = (state == ACTIVE) && lcd_on;
    fifo_full = (count == CNT_W'(FIFO_DEPTH));
    pop       = fb_we && fb_ready;
    px_room   = (col < COL_W'(LINE_W));
    push      = in_active && px_valid && px_room && (!fifo_full || pop);
    ovf_drop  = in_active && px_valid && px_room && fifo_full && !pop;
    over_drop = in_active && px_valid && !px_room;
    line_end  = in_active && (prev_mode == MODE_DRAW) && (ppu_mode == MODE_HBLANK);
    shade     = bgp[{px_in, 1'b0} +: 2];
  end

  // Frame/line tracking state machine with sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      row        <= '0;
      col        <= '0;
      line_base  <= FB_BASE;
      prev_mode  <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode;
      frame_done <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (err_clr) begin
        line_err <= 1'b0;
        ovf_err  <= 1'b0;
      end
      if (ovf_drop)  ovf_err  <= 1'b1;
      if (over_drop) line_err <= 1'b1;
      if (!lcd_on) begin
        state <= SYNC;
      end else begin
        case (state)
          SYNC: begin
            if (ppu_mode == MODE_VBLANK) state <= WAIT_VB_END;
          end
          WAIT_VB_END: begin
            if (ppu_mode != MODE_VBLANK) begin
              state     <= ACTIVE;
              row       <= '0;
              col       <= '0;
              line_base <= FB_BASE;
            end
          end
          ACTIVE: begin
            // Overflow-dropped pixels still consume their column slot.
            if (px_valid && px_room) col <= col + 1'b1;
            if (line_end) begin
              if (col != COL_W'(LINE_W)) line_err <= 1'b1;
              col       <= '0;
              row       <= row + 1'b1;
              line_base <= line_base + 15'(LINE_W);
            end
            if (ppu_mode == MODE_VBLANK) begin
              state <= FRAME_END;
              if (row != ROW_W'(LINES)) line_err <= 1'b1;
            end
          end
          FRAME_END: begin
            if (count == '0) begin
              frame_done <= 1'b1;
              state      <= WAIT_VB_END;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  // Pending-write FIFO; head entry drives the framebuffer port directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= line_base + 15'(col);
        mem_data[wr_ptr] <= shade;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
